// File: rtl/frame_router_pkg.sv
// frame_router_pkg: shared types and constants for the frame router.
//   LEN_WIDTH         : width of the frame length byte and payload counters
//   SYNC_BYTE_DEFAULT : default frame start marker
//   rx_state_t        : RX parser states
//   tx_state_t        : TX framer states
//   wrap_inc          : (base + step) mod n, for base < n and step <= n
package frame_router_pkg;

   localparam int unsigned LEN_WIDTH         = 8;
   localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      R_IDLE,
      R_CH,
      R_LEN,
      R_PAY,
      R_DROP
   } rx_state_t;

   typedef enum logic [2:0] {
      T_IDLE,
      T_SYNC,
      T_CH,
      T_LEN,
      T_PAY
   } tx_state_t;

   function automatic int unsigned wrap_inc(input int unsigned base,
                                            input int unsigned step,
                                            input int unsigned n);
      int unsigned s;
      s = base + step;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
//   req_i   : request vector, one bit per channel
//   ptr_i   : highest-priority channel index (search starts here and wraps)
//   grant_o : one-hot grant, all zero when no request is pending
//   idx_o   : index of the granted channel (0 when no request)
module rr_arbiter
   import frame_router_pkg::*;
#(
   parameter  int unsigned NUM_CH = 4,
   localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [IDX_W-1:0]  idx_o
);

   int unsigned cand;
   logic        found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = 0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cand = wrap_inc(32'(ptr_i), i, NUM_CH);
         if (!found && req_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/frame_router.sv
// frame_router: routes framed byte streams between one serial link and
// NUM_CH endpoints. Frame: SYNC_BYTE, channel id, length L, L+1 payload bytes.
//   clk, rst                           : clock, async active-high reset
//   s_rx_data/valid/ready              : bytes from the serial RX FIFO
//   m_ch_data/valid/ready              : payload to endpoints (lane per channel)
//   s_ch_data/len/valid/ready          : response payload from endpoints
//   m_tx_data/valid/ready              : bytes to the serial TX FIFO
//   err_bad_ch                         : pulse when an RX header names a channel >= NUM_CH
module frame_router
   import frame_router_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH = 8,
   parameter int unsigned            NUM_CH     = 4,
   parameter logic [DATA_WIDTH-1:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_WIDTH-1:0]          s_rx_data,
   input  logic                           s_rx_valid,
   output logic                           s_rx_ready,
   output logic [NUM_CH*DATA_WIDTH-1:0]   m_ch_data,
   output logic [NUM_CH-1:0]              m_ch_valid,
   input  logic [NUM_CH-1:0]              m_ch_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   s_ch_data,
   input  logic [NUM_CH*LEN_WIDTH-1:0]    s_ch_len,
   input  logic [NUM_CH-1:0]              s_ch_valid,
   output logic [NUM_CH-1:0]              s_ch_ready,
   output logic [DATA_WIDTH-1:0]          m_tx_data,
   output logic                           m_tx_valid,
   input  logic                           m_tx_ready,
   output logic                           err_bad_ch
);

   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // ---------------- RX path ----------------
   rx_state_t             rx_state_q;
   logic [CH_W-1:0]       rx_ch_q;
   logic                  rx_drop_q;
   logic [LEN_WIDTH-1:0]  rx_cnt_q;
   logic                  rx_acc;
   logic                  rx_bad_id;

   assign rx_acc    = s_rx_valid & s_rx_ready;
   assign rx_bad_id = (32'(s_rx_data) >= NUM_CH);

   // Outputs decode the registered state combinationally so the payload
   // handshake passes straight through with zero latency.
   always_comb begin
      s_rx_ready = 1'b0;
      m_ch_valid = '0;
      err_bad_ch = 1'b0;
      m_ch_data  = rst ? '0 : {NUM_CH{s_rx_data}};
      if (!rst) begin
         case (rx_state_q)
            R_PAY: begin
               s_rx_ready          = m_ch_ready[rx_ch_q];
               m_ch_valid[rx_ch_q] = s_rx_valid;
            end
            default: s_rx_ready = 1'b1;
         endcase
         if (rx_state_q == R_CH && rx_acc && rx_bad_id) err_bad_ch = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q <= R_IDLE;
         rx_ch_q    <= '0;
         rx_drop_q  <= 1'b0;
         rx_cnt_q   <= '0;
      end else if (rx_acc) begin
         unique case (rx_state_q)
            R_IDLE: if (s_rx_data == SYNC_BYTE) rx_state_q <= R_CH;
            R_CH: begin
               rx_ch_q    <= s_rx_data[CH_W-1:0];
               rx_drop_q  <= rx_bad_id;
               rx_state_q <= R_LEN;
            end
            R_LEN: begin
               rx_cnt_q   <= LEN_WIDTH'(s_rx_data);
               rx_state_q <= rx_drop_q ? R_DROP : R_PAY;
            end
            R_PAY, R_DROP: begin
               if (rx_cnt_q == '0) rx_state_q <= R_IDLE;
               else                rx_cnt_q   <= rx_cnt_q - 1'b1;
            end
            default: rx_state_q <= R_IDLE;
         endcase
      end
   end

   // ---------------- TX path ----------------
   tx_state_t             tx_state_q;
   logic [CH_W-1:0]       tx_grant_q;
   logic [LEN_WIDTH-1:0]  tx_len_q;
   logic [LEN_WIDTH-1:0]  tx_cnt_q;
   logic [CH_W-1:0]       rr_ptr_q;

   logic [DATA_WIDTH-1:0] ch_data_a [NUM_CH];
   logic [LEN_WIDTH-1:0]  ch_len_a  [NUM_CH];
   logic [NUM_CH-1:0]     arb_grant;
   logic [CH_W-1:0]       arb_idx;
   logic                  arb_valid;
   logic                  tx_acc;

   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ch_data_a[i] = s_ch_data[i*DATA_WIDTH +: DATA_WIDTH];
         ch_len_a[i]  = s_ch_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
   end

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req_i   (s_ch_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx)
   );

   assign arb_valid = |arb_grant;
   assign tx_acc    = m_tx_valid & m_tx_ready;

   always_comb begin
      m_tx_valid = 1'b0;
      m_tx_data  = '0;
      s_ch_ready = '0;
      if (!rst) begin
         case (tx_state_q)
            T_SYNC: begin
               m_tx_valid = 1'b1;
               m_tx_data  = SYNC_BYTE;
            end
            T_CH: begin
               m_tx_valid = 1'b1;
               m_tx_data  = DATA_WIDTH'(tx_grant_q);
            end
            T_LEN: begin
               m_tx_valid = 1'b1;
               m_tx_data  = DATA_WIDTH'(tx_len_q);
            end
            T_PAY: begin
               m_tx_data              = ch_data_a[tx_grant_q];
               m_tx_valid             = s_ch_valid[tx_grant_q];
               s_ch_ready[tx_grant_q] = m_tx_ready;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= T_IDLE;
         tx_grant_q <= '0;
         tx_len_q   <= '0;
         tx_cnt_q   <= '0;
         rr_ptr_q   <= '0;
      end else begin
         unique case (tx_state_q)
            T_IDLE: if (arb_valid) begin
               tx_grant_q <= arb_idx;
               tx_len_q   <= ch_len_a[arb_idx];
               tx_state_q <= T_SYNC;
            end
            T_SYNC: if (m_tx_ready) tx_state_q <= T_CH;
            T_CH:   if (m_tx_ready) tx_state_q <= T_LEN;
            T_LEN: if (m_tx_ready) begin
               tx_cnt_q   <= tx_len_q;
               tx_state_q <= T_PAY;
            end
            T_PAY: if (tx_acc) begin
               if (tx_cnt_q == '0) begin
                  rr_ptr_q   <= CH_W'(wrap_inc(32'(tx_grant_q), 1, NUM_CH));
                  tx_state_q <= T_IDLE;
               end else begin
                  tx_cnt_q <= tx_cnt_q - 1'b1;
               end
            end
            default: tx_state_q <= T_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_router.sv
// tb_frame_router: directed self-checking bench for frame_router (NUM_CH=4).
module tb_frame_router;
   import frame_router_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_rx_data = '0;
   logic        s_rx_valid = 1'b0;
   logic        s_rx_ready;
   logic [31:0] m_ch_data;
   logic [3:0]  m_ch_valid;
   logic [3:0]  m_ch_ready = '1;
   logic [31:0] s_ch_data = '0;
   logic [31:0] s_ch_len = '0;
   logic [3:0]  s_ch_valid = '0;
   logic [3:0]  s_ch_ready;
   logic [7:0]  m_tx_data;
   logic        m_tx_valid;
   logic        m_tx_ready = 1'b1;
   logic        err_bad_ch;

   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

   logic [15:0] fwd_q[$];
   int unsigned err_cnt = 0;
   logic [7:0]  tx_q[$];
   int unsigned rr_hist[$];

   int unsigned src_left[4];
   logic [7:0]  src_next[4];
   logic [7:0]  src_len[4];

   frame_router #(
      .DATA_WIDTH (8),
      .NUM_CH     (4),
      .SYNC_BYTE  (8'hA5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_rx_data  (s_rx_data),
      .s_rx_valid (s_rx_valid),
      .s_rx_ready (s_rx_ready),
      .m_ch_data  (m_ch_data),
      .m_ch_valid (m_ch_valid),
      .m_ch_ready (m_ch_ready),
      .s_ch_data  (s_ch_data),
      .s_ch_len   (s_ch_len),
      .s_ch_valid (s_ch_valid),
      .s_ch_ready (s_ch_ready),
      .m_tx_data  (m_tx_data),
      .m_tx_valid (m_tx_valid),
      .m_tx_ready (m_tx_ready),
      .err_bad_ch (err_bad_ch)
   );

   always #5 clk = ~clk;

   // Records every endpoint delivery as {channel, byte} and counts error pulses.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++)
            if (m_ch_valid[i] && m_ch_ready[i]) fwd_q.push_back({8'(i), m_ch_data[i*8 +: 8]});
         if (err_bad_ch) err_cnt++;
      end
   end

   // Presents one RX byte until accepted; starts and ends at posedge+1.
   task automatic rx_send(input logic [7:0] b);
      bit acc;
      acc = 1'b0;
      s_rx_data  = b;
      s_rx_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         acc = s_rx_ready;
         @(posedge clk); #1;
         if (acc) break;
      end
      s_rx_valid = 1'b0;
      if (!acc) begin
         total_cnt++;
         $display("FAIL rx_send_timeout: byte %h never accepted", b);
      end
   endtask

   task automatic src_start(input int ch, input logic [7:0] len, input logic [7:0] base);
      src_left[ch] = 32'(len) + 1;
      src_next[ch] = base;
      src_len[ch]  = len;
   endtask

   // Drives all endpoint sources until drained, collecting TX bytes and rr_ptr changes.
   task automatic run_tx(input int unsigned max_cycles, input bit toggle, input bit scramble);
      int unsigned n;
      bit busy;
      tx_q.delete();
      rr_hist.delete();
      rr_hist.push_back(32'(dut.rr_ptr_q));
      n = 0;
      busy = 1'b1;
      m_tx_ready = 1'b1;
      while (busy && n < max_cycles) begin
         for (int i = 0; i < 4; i++) begin
            s_ch_valid[i]       = (src_left[i] != 0);
            s_ch_data[i*8 +: 8] = src_next[i];
            s_ch_len[i*8 +: 8]  = (scramble && tx_q.size() > 3) ? ~src_len[i] : src_len[i];
         end
         @(negedge clk);
         if (m_tx_valid && m_tx_ready) tx_q.push_back(m_tx_data);
         for (int i = 0; i < 4; i++)
            if (s_ch_valid[i] && s_ch_ready[i]) begin
               src_left[i]--;
               src_next[i]++;
            end
         @(posedge clk); #1;
         n++;
         if (toggle) m_tx_ready = ~m_tx_ready;
         if (32'(dut.rr_ptr_q) != rr_hist[$]) rr_hist.push_back(32'(dut.rr_ptr_q));
         busy = (src_left[0] != 0) || (src_left[1] != 0) || (src_left[2] != 0) || (src_left[3] != 0);
      end
      s_ch_valid = '0;
      m_tx_ready = 1'b1;
      total_cnt++;
      if (busy) $display("FAIL tx_drain_timeout: sources busy=%0d after %0d cycles want 0", busy, n);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s_rx_valid = 1'b1; s_rx_data = 8'hA5;
      s_ch_valid = '1; s_ch_data = 32'hC3C2C1C0; s_ch_len = '0;
      m_ch_ready = '1; m_tx_ready = 1'b1;
      @(negedge clk);
      total_cnt++; if (s_rx_ready !== 1'b0) $display("FAIL rst_rx_ready: got %b want 0", s_rx_ready); else pass_cnt++;
      total_cnt++; if (m_ch_valid !== 4'h0) $display("FAIL rst_ch_valid: got %h want 0", m_ch_valid); else pass_cnt++;
      total_cnt++; if (s_ch_ready !== 4'h0) $display("FAIL rst_ch_ready: got %h want 0", s_ch_ready); else pass_cnt++;
      total_cnt++; if (m_tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b want 0", m_tx_valid); else pass_cnt++;
      total_cnt++; if (m_tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", m_tx_data); else pass_cnt++;
      total_cnt++; if (err_bad_ch !== 1'b0) $display("FAIL rst_err: got %b want 0", err_bad_ch); else pass_cnt++;
      total_cnt++; if (dut.rx_state_q !== R_IDLE) $display("FAIL rst_rx_state: got %0d want R_IDLE", dut.rx_state_q); else pass_cnt++;
      total_cnt++; if (dut.tx_state_q !== T_IDLE) $display("FAIL rst_tx_state: got %0d want T_IDLE", dut.tx_state_q); else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0;
      s_rx_valid = 1'b0;
      s_ch_valid = '0;
   endtask

   task automatic test_rx_route();
      logic [7:0]  v1[6];
      logic [7:0]  v2[5];
      int unsigned base, e0;
      base = fwd_q.size();
      e0 = err_cnt;
      v1 = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h33};
      foreach (v1[i]) rx_send(v1[i]);
      total_cnt++; if (fwd_q.size() - base !== 3) $display("FAIL route_count: got %0d want 3", fwd_q.size() - base); else pass_cnt++;
      total_cnt++; if (fwd_q[base] !== 16'h0111) $display("FAIL route_b0: got %h want 0111", fwd_q[base]); else pass_cnt++;
      total_cnt++; if (fwd_q[base+1] !== 16'h0122) $display("FAIL route_b1: got %h want 0122", fwd_q[base+1]); else pass_cnt++;
      total_cnt++; if (fwd_q[base+2] !== 16'h0133) $display("FAIL route_b2: got %h want 0133", fwd_q[base+2]); else pass_cnt++;
      // SYNC value inside the payload is plain data
      base = fwd_q.size();
      v2 = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5};
      foreach (v2[i]) rx_send(v2[i]);
      total_cnt++; if (fwd_q.size() - base !== 2) $display("FAIL sync_data_count: got %0d want 2", fwd_q.size() - base); else pass_cnt++;
      total_cnt++; if (fwd_q[base] !== 16'h00A5 || fwd_q[base+1] !== 16'h00A5) $display("FAIL sync_data_vals: got %h %h want 00a5 00a5", fwd_q[base], fwd_q[base+1]); else pass_cnt++;
      total_cnt++; if (err_cnt !== e0) $display("FAIL route_no_err: got %0d want %0d", err_cnt, e0); else pass_cnt++;
   endtask

   task automatic test_rx_backpressure();
      int unsigned base;
      base = fwd_q.size();
      rx_send(8'hA5); rx_send(8'h01); rx_send(8'h01);
      m_ch_ready = 4'b1101;
      s_rx_data = 8'h66; s_rx_valid = 1'b1;
      @(negedge clk);
      total_cnt++; if (s_rx_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", s_rx_ready); else pass_cnt++;
      total_cnt++; if (m_ch_valid !== 4'b0010) $display("FAIL bp_valid_mask: got %b want 0010", m_ch_valid); else pass_cnt++;
      total_cnt++; if (m_ch_data !== 32'h66666666) $display("FAIL bp_lanes: got %h want 66666666", m_ch_data); else pass_cnt++;
      @(posedge clk); #1;
      m_ch_ready = '1;
      @(negedge clk);
      total_cnt++; if (s_rx_ready !== 1'b1) $display("FAIL bp_ready_high: got %b want 1", s_rx_ready); else pass_cnt++;
      @(posedge clk); #1;
      s_rx_valid = 1'b0;
      rx_send(8'h77);
      total_cnt++; if (fwd_q.size() - base !== 2) $display("FAIL bp_count: got %0d want 2", fwd_q.size() - base); else pass_cnt++;
      total_cnt++; if (fwd_q[base] !== 16'h0166 || fwd_q[base+1] !== 16'h0177) $display("FAIL bp_vals: got %h %h want 0166 0177", fwd_q[base], fwd_q[base+1]); else pass_cnt++;
   endtask

   task automatic test_rx_bad_ch();
      logic [7:0]  v[6];
      int unsigned base, e0;
      base = fwd_q.size();
      e0 = err_cnt;
      v = '{8'h00, 8'h7F, 8'hA5, 8'h07, 8'h00, 8'h55};
      foreach (v[i]) rx_send(v[i]);
      total_cnt++; if (err_cnt - e0 !== 1) $display("FAIL bad_ch_err: got %0d pulses want 1", err_cnt - e0); else pass_cnt++;
      total_cnt++; if (fwd_q.size() - base !== 0) $display("FAIL bad_ch_fwd: got %0d want 0", fwd_q.size() - base); else pass_cnt++;
      rx_send(8'hA5); rx_send(8'h02); rx_send(8'h00); rx_send(8'h5A);
      total_cnt++; if (fwd_q.size() - base !== 1) $display("FAIL after_drop_count: got %0d want 1", fwd_q.size() - base); else pass_cnt++;
      total_cnt++; if (fwd_q[base] !== 16'h025A) $display("FAIL after_drop_val: got %h want 025a", fwd_q[base]); else pass_cnt++;
   endtask

   task automatic test_tx_rr();
      logic [7:0] exp[8];
      int unsigned mm;
      exp = '{8'hA5, 8'h00, 8'h00, 8'hC0, 8'hA5, 8'h02, 8'h00, 8'hC2};
      src_start(0, 8'h00, 8'hC0);
      src_start(2, 8'h00, 8'hC2);
      run_tx(100, 1'b0, 1'b0);
      mm = 0;
      for (int i = 0; i < 8; i++) if (i >= tx_q.size() || tx_q[i] !== exp[i]) mm++;
      total_cnt++; if (tx_q.size() !== 8) $display("FAIL rr_tx_len: got %0d want 8", tx_q.size()); else pass_cnt++;
      total_cnt++; if (mm !== 0) $display("FAIL rr_tx_bytes: got %0d mismatches want 0", mm); else pass_cnt++;
      total_cnt++; if (rr_hist.size() !== 3 || rr_hist[0] !== 0 || rr_hist[1] !== 1 || rr_hist[2] !== 3)
         $display("FAIL rr_seq: got n=%0d %0d,%0d,%0d want 0,1,3", rr_hist.size(), rr_hist[0], rr_hist[1], rr_hist[2]);
      else pass_cnt++;
   endtask

   task automatic test_tx_repeat();
      logic [7:0] exp[4];
      int unsigned mm;
      exp = '{8'hA5, 8'h02, 8'h00, 8'hC2};
      src_start(2, 8'h00, 8'hC2);
      run_tx(100, 1'b0, 1'b0);
      mm = 0;
      for (int i = 0; i < 4; i++) if (i >= tx_q.size() || tx_q[i] !== exp[i]) mm++;
      total_cnt++; if (tx_q.size() !== 4 || mm !== 0) $display("FAIL repeat_bytes: got n=%0d mm=%0d want n=4 mm=0", tx_q.size(), mm); else pass_cnt++;
      total_cnt++; if (rr_hist.size() !== 1 || rr_hist[0] !== 3) $display("FAIL repeat_rr: got n=%0d first=%0d want 3 only", rr_hist.size(), rr_hist[0]); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [7:0]  exp[6];
      int unsigned base, mm;
      exp = '{8'hA5, 8'h03, 8'h02, 8'hD0, 8'hD1, 8'hD2};
      base = fwd_q.size();
      src_start(3, 8'h02, 8'hD0);
      fork
         run_tx(200, 1'b0, 1'b0);
         begin
            rx_send(8'hA5); rx_send(8'h00); rx_send(8'h01); rx_send(8'hE1); rx_send(8'hE2);
         end
      join
      mm = 0;
      for (int i = 0; i < 6; i++) if (i >= tx_q.size() || tx_q[i] !== exp[i]) mm++;
      total_cnt++; if (tx_q.size() !== 6 || mm !== 0) $display("FAIL concurrent_tx: got n=%0d mm=%0d want n=6 mm=0", tx_q.size(), mm); else pass_cnt++;
      total_cnt++; if (fwd_q.size() - base !== 2 || fwd_q[base] !== 16'h00E1 || fwd_q[base+1] !== 16'h00E2)
         $display("FAIL concurrent_rx: got n=%0d %h %h want 00e1 00e2", fwd_q.size() - base, fwd_q[base], fwd_q[base+1]);
      else pass_cnt++;
      total_cnt++; if (dut.rr_ptr_q !== 2'd0) $display("FAIL concurrent_rr: got %0d want 0", dut.rr_ptr_q); else pass_cnt++;
   endtask

   task automatic test_tx_long();
      int unsigned mm;
      logic [7:0]  e;
      src_start(1, 8'hFF, 8'h00);
      run_tx(2000, 1'b1, 1'b1);
      mm = 0;
      for (int i = 0; i < 259; i++) begin
         e = (i == 0) ? 8'hA5 : (i == 1) ? 8'h01 : (i == 2) ? 8'hFF : 8'(i - 3);
         if (i >= tx_q.size() || tx_q[i] !== e) mm++;
      end
      total_cnt++; if (tx_q.size() !== 259) $display("FAIL long_len: got %0d want 259", tx_q.size()); else pass_cnt++;
      total_cnt++; if (mm !== 0) $display("FAIL long_bytes: got %0d mismatches want 0", mm); else pass_cnt++;
      total_cnt++; if (dut.rr_ptr_q !== 2'd2) $display("FAIL long_rr: got %0d want 2", dut.rr_ptr_q); else pass_cnt++;
   endtask

   task automatic test_reset_midframe();
      int unsigned base;
      rx_send(8'hA5); rx_send(8'h00); rx_send(8'h04); rx_send(8'h10); rx_send(8'h20);
      rst = 1'b1;
      s_rx_data = 8'h30; s_rx_valid = 1'b1;
      s_ch_valid = 4'b1000; s_ch_data = 32'h5A000000; s_ch_len = 32'h01000000;
      @(negedge clk);
      total_cnt++; if (s_rx_ready !== 1'b0 || m_ch_valid !== 4'h0 || m_ch_data !== 32'h0)
         $display("FAIL midrst_rx_outs: got rdy=%b v=%h d=%h want 0", s_rx_ready, m_ch_valid, m_ch_data);
      else pass_cnt++;
      total_cnt++; if (s_ch_ready !== 4'h0 || m_tx_valid !== 1'b0 || m_tx_data !== 8'h00 || err_bad_ch !== 1'b0)
         $display("FAIL midrst_tx_outs: got rdy=%h v=%b d=%h err=%b want 0", s_ch_ready, m_tx_valid, m_tx_data, err_bad_ch);
      else pass_cnt++;
      total_cnt++; if (dut.rr_ptr_q !== 2'd0) $display("FAIL midrst_rr: got %0d want 0", dut.rr_ptr_q); else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0;
      s_rx_valid = 1'b0;
      s_ch_valid = '0;
      base = fwd_q.size();
      rx_send(8'hA5); rx_send(8'h03); rx_send(8'h00); rx_send(8'h9A);
      total_cnt++; if (fwd_q.size() - base !== 1 || fwd_q[base] !== 16'h039A)
         $display("FAIL post_rst_frame: got n=%0d %h want 039a", fwd_q.size() - base, fwd_q[base]);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_rx_route();
      test_rx_backpressure();
      test_rx_bad_ch();
      test_tx_rr();
      test_tx_repeat();
      test_back_to_back();
      test_tx_long();
      test_reset_midframe();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/frame_router.md
FRAME_ROUTER -- requirements
Module: frame_router

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width of every stream; only 8 is supported.
REQ-002 Parameter NUM_CH, default 4, number of endpoint channels (2..16).
REQ-003 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-004 clk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_rx_data/s_rx_valid/s_rx_ready  in/in/out  8/1/1  byte stream from the serial RX FIFO.
REQ-007 m_ch_data/m_ch_valid/m_ch_ready  out/out/in  NUM_CH*8/NUM_CH/NUM_CH  routed payload to each endpoint.
REQ-008 s_ch_data/s_ch_len/s_ch_valid/s_ch_ready  in/in/in/out  NUM_CH*8/NUM_CH*8/NUM_CH/NUM_CH  response payload from each endpoint.
REQ-009 m_tx_data/m_tx_valid/m_tx_ready  out/out/in  8/1/1  byte stream to the serial TX FIFO.
REQ-010 err_bad_ch  output  1  one-cycle pulse when an RX header names a channel >= NUM_CH.

Function
REQ-011 Frame format, both directions: SYNC_BYTE, channel id, length byte L, then L+1 payload bytes (1..256); there are no empty frames.
REQ-012 Every transfer is a valid&&ready handshake; valid, once asserted, stays asserted with data stable until accepted.
REQ-013 RX FSM states: R_IDLE, R_CH, R_LEN, R_PAY, R_DROP.
REQ-014 R_IDLE: s_rx_ready=1; SYNC_BYTE goes to R_CH, and any other byte is consumed and discarded.
REQ-015 R_CH: capture the id and go to R_LEN; if id >= NUM_CH, set a drop flag and pulse err_bad_ch on the accept cycle.
REQ-016 R_LEN: load the down-counter with L and go to R_PAY, or to R_DROP if the drop flag is set.
REQ-017 R_PAY: m_ch_valid[cur] = s_rx_valid and s_rx_ready = m_ch_ready[cur], combinationally (zero latency).
REQ-018 R_PAY: every other m_ch_valid bit is 0, and all m_ch_data lanes carry s_rx_data.
REQ-019 R_PAY: on each accept the counter decrements; an accept with counter==0 returns to R_IDLE.
REQ-020 R_DROP: s_rx_ready=1 and bytes are consumed with the same count rule, with nothing forwarded.
REQ-021 A SYNC_BYTE value inside the header or payload is ordinary data; there is no resynchronisation mid-frame.
REQ-022 TX FSM states: T_IDLE, T_SYNC, T_CH, T_LEN, T_PAY.
REQ-023 T_IDLE: grant the first asserted s_ch_valid at or after rr_ptr (wrapping), register the grant and s_ch_len[grant], and go to T_SYNC the next cycle.
REQ-024 T_IDLE with no valid channel: remain in T_IDLE.
REQ-025 T_SYNC/T_CH/T_LEN: drive SYNC_BYTE, grant id, and latched length in turn, each advancing on m_tx_ready.
REQ-026 T_PAY: m_tx_data = s_ch_data[grant], m_tx_valid = s_ch_valid[grant], s_ch_ready[grant] = m_tx_ready, combinationally.
REQ-027 T_PAY: all other s_ch_ready bits are 0, and an accept with counter==0 ends the frame.
REQ-028 Frame end: rr_ptr = (grant+1) mod NUM_CH, then return to T_IDLE.
REQ-029 Mid-frame, the granted source changing s_ch_len has no effect; only the value latched at grant is used.
REQ-030 RX and TX paths are fully independent; simultaneous activity on both never stalls either.
REQ-031 Counters are 8-bit; L=255 yields exactly 256 payload bytes with no wrap error.

Reset
REQ-032 While rst is high: both FSMs are in their IDLE state, and rr_ptr, counters, grant and drop flag are 0.
REQ-033 While rst is high: s_rx_ready, m_ch_valid, s_ch_ready, m_tx_valid and err_bad_ch are 0, and m_tx_data is 0.
REQ-034 rst asserted mid-frame aborts both frames immediately; partial frames are neither completed nor resumed.
REQ-035 The first byte after reset release is parsed in R_IDLE.

Structure
REQ-036 Package frame_router_pkg holds SYNC_BYTE default, rx_state_t, tx_state_t and LEN_WIDTH=8.
REQ-037 Round-robin selection is the sub-module rr_arbiter (NUM_CH requests, rr_ptr in, one-hot grant and index out).
REQ-038 The RX and TX FSMs live in frame_router itself.

Verification
REQ-039 RX bytes A5,01,02,11,22,33 with all ready=1 -> m_ch_valid[1] carries 11,22,33; other channels stay silent; FSM returns to R_IDLE.
REQ-040 RX bytes 00,7F,A5,07,00,55 with NUM_CH=4 -> 00,7F discarded; err_bad_ch pulses once; 55 is consumed and not forwarded.
REQ-041 Channels 0 and 2 each request with len=0 (data C0 / C2) and rr_ptr=0 -> TX emits A5,00,00,C0 then A5,02,00,C2.
REQ-042 Channel 2 requests again -> its frame follows, and the rr_ptr sequence is 0,1,3,3.
REQ-043 m_tx_ready toggled 1/0 every cycle during a 256-byte frame (len=FF) -> exactly 259 bytes out, no duplicates or losses.
REQ-044 rst pulsed after the 2nd payload byte of an RX frame A5,00,04,... -> all outputs are 0 during reset, and a fresh frame A5,03,00,9A then routes 9A to channel 3.
